// File: rtl/adder_pkg.sv
// Shared types and defaults for the Adder event-filter front end.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } filt_state_t;

  localparam int unsigned DEBOUNCE_DEF = 4;
  localparam int unsigned GW_DEF       = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, cleared by srst.
module sync_2ff (
  input  logic aclk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the async input through two flops before anyone looks at it.
  always_ff @(posedge aclk) begin
    if (srst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adder_event_filter.sv
// Debounces a raw event line into single inc pulses, turns a clear-request
// level into single clr pulses, and keeps the two mutually exclusive.
module adder_event_filter
  import adder_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEF,
  parameter int unsigned GW       = GW_DEF
) (
  input  logic          aclk,
  input  logic          srst,
  input  logic          evt_in,
  input  logic          clr_req,
  output logic          inc,
  output logic          clr,
  output logic          evt_level,
  output logic [GW-1:0] glitch_cnt
);

  localparam int unsigned       CNT_W    = $clog2(DEBOUNCE);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  filt_state_t      state;
  filt_state_t      state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             evt_s;
  logic             inc_req_c;
  logic             glitch_hit_c;
  logic             clr_pulse_c;
  logic             clr_req_d;
  logic             pending;

  sync_2ff u_sync_evt (
    .aclk (aclk),
    .srst (srst),
    .d    (evt_in),
    .q    (evt_s)
  );

  // FSM state and debounce counter registers.
  always_ff @(posedge aclk) begin
    if (srst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Debounce decisions: accept an edge only after DEBOUNCE stable samples.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    inc_req_c    = 1'b0;
    glitch_hit_c = 1'b0;
    case (state)
      IDLE: begin
        if (evt_s) begin
          state_next = RISE_CHK;
          cnt_next   = CNT_ONE;
        end
      end
      RISE_CHK: begin
        if (!evt_s) begin
          state_next   = IDLE;
          glitch_hit_c = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_next = HIGH;
          inc_req_c  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (!evt_s) begin
          state_next = FALL_CHK;
          cnt_next   = CNT_ONE;
        end
      end
      FALL_CHK: begin
        if (evt_s) begin
          state_next = HIGH;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign clr_pulse_c = clr_req & ~clr_req_d;

  // Output pulses: clr always wins a collision; the displaced inc is held
  // in pending and emitted on the first edge without a clr pulse.
  always_ff @(posedge aclk) begin
    if (srst) begin
      inc        <= 1'b0;
      clr        <= 1'b0;
      evt_level  <= 1'b0;
      glitch_cnt <= '0;
      pending    <= 1'b0;
      clr_req_d  <= 1'b0;
    end else begin
      clr_req_d <= clr_req;
      clr       <= clr_pulse_c;
      evt_level <= (state_next == HIGH) || (state_next == FALL_CHK);
      if (clr_pulse_c) begin
        inc     <= 1'b0;
        pending <= pending | inc_req_c;
      end else begin
        inc     <= inc_req_c | pending;
        pending <= 1'b0;
      end
      if (glitch_hit_c && (glitch_cnt != '1)) begin
        glitch_cnt <= glitch_cnt + GW'(1);
      end
    end
  end

endmodule

// File: tb/tb_adder_event_filter.sv
// Directed and randomized checks of adder_event_filter against a run-length
// reference model of the debounce and pulse-arbitration rules.
module tb_adder_event_filter;

  localparam int unsigned DEBOUNCE = 4;
  localparam int unsigned GW       = 8;
  localparam int unsigned GMAX     = 255;

  logic          aclk;
  logic          srst;
  logic          evt_in;
  logic          clr_req;
  logic          inc;
  logic          clr;
  logic          evt_level;
  logic [GW-1:0] glitch_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic m_d1 = 1'b0;
  logic m_d2 = 1'b0;
  logic m_level = 1'b0;
  int   m_run = 0;
  int   m_glitch = 0;
  int   m_owed = 0;
  logic m_clr_prev = 1'b0;
  logic m_inc = 1'b0;
  logic m_clr = 1'b0;

  // Observed-side bookkeeping
  int inc_seen = 0;
  int dut_count = 0;

  adder_event_filter #(
    .DEBOUNCE (DEBOUNCE),
    .GW       (GW)
  ) dut (
    .aclk       (aclk),
    .srst       (srst),
    .evt_in     (evt_in),
    .clr_req    (clr_req),
    .inc        (inc),
    .clr        (clr),
    .evt_level  (evt_level),
    .glitch_cnt (glitch_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // The model tracks how many consecutive samples disagree with the accepted
  // level; DEBOUNCE of them flips the level. A rising run cut short is a glitch.
  task automatic model_update(input logic e, input logic c, input logic r);
    logic s;
    logic rise;
    logic pulse;
    if (r) begin
      m_d1 = 1'b0; m_d2 = 1'b0; m_level = 1'b0; m_run = 0; m_glitch = 0;
      m_owed = 0; m_clr_prev = 1'b0; m_inc = 1'b0; m_clr = 1'b0;
      dut_count = 0;
      return;
    end
    s    = m_d2;
    m_d2 = m_d1;
    m_d1 = e;
    rise = 1'b0;
    if (s != m_level) begin
      m_run++;
      if (m_run == int'(DEBOUNCE)) begin
        m_level = s;
        m_run   = 0;
        rise    = s;
      end
    end else begin
      if (m_run > 0 && !m_level && m_glitch < int'(GMAX)) m_glitch++;
      m_run = 0;
    end
    pulse      = c & ~m_clr_prev;
    m_clr_prev = c;
    m_clr      = pulse;
    if (pulse) begin
      m_inc  = 1'b0;
      m_owed = m_owed + int'(rise);
    end else begin
      m_inc  = (m_owed > 0) || rise;
      m_owed = 0;
    end
  endtask

  task automatic check_all();
    chk("inc", 32'(inc), 32'(m_inc));
    chk("clr", 32'(clr), 32'(m_clr));
    chk("evt_level", 32'(evt_level), 32'(m_level));
    chk("glitch_cnt", 32'(glitch_cnt), 32'(m_glitch));
    chk("inc_clr_excl", 32'(inc && clr), 32'd0);
    if (clr) dut_count = 0;
    else if (inc) dut_count++;
    if (inc) inc_seen++;
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare mid-cycle.
  task automatic step(input logic e, input logic c, input logic r);
    evt_in  = e;
    clr_req = c;
    srst    = r;
    @(posedge aclk);
    model_update(e, c, r);
    @(negedge aclk);
    check_all();
  endtask

  initial begin
    int base;
    int n;
    logic v;
    logic cur_clr;
    int len;

    evt_in = 1'b0; clr_req = 1'b0; srst = 1'b1;

    // Reset
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
    chk("rst_inc", 32'(inc), 32'd0);
    chk("rst_level", 32'(evt_level), 32'd0);
    chk("rst_glitch", 32'(glitch_cnt), 32'd0);

    // Clean rising edge: inc only after edge DEBOUNCE+1
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("clean_inc_latency", 32'(inc), 32'(i == 5));
      chk("clean_level", 32'(evt_level), 32'(i >= 5));
    end
    base = inc_seen;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    chk("held_no_reinc", 32'(inc_seen - base), 32'd0);
    // Falling edge: level drops five edges later, no pulse
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("fall_level", 32'(evt_level), 32'(i < 5));
      chk("fall_no_inc", 32'(inc), 32'd0);
    end

    // Single glitch, then saturation
    base = inc_seen;
    step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
    chk("glitch_one", 32'(glitch_cnt), 32'd1);
    for (int k = 0; k < 299; k++) begin
      step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
    end
    chk("glitch_saturate", 32'(glitch_cnt), 32'd255);
    chk("glitch_no_inc", 32'(inc_seen - base), 32'd0);

    // Bounce: three rejects then a stable high
    step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
    base = inc_seen;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    chk("bounce_one_inc", 32'(inc_seen - base), 32'd1);
    chk("bounce_glitch", 32'(glitch_cnt), 32'd3);
    // Short low dip while high
    base = inc_seen;
    step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("dip_level", 32'(evt_level), 32'd1);
    end
    chk("dip_no_inc", 32'(inc_seen - base), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);

    // Clear request held: one pulse
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("clr_single", 32'(clr), 32'(i == 0));
    end
    step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);

    // Collision: clr pulse lands on the inc edge
    step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'(i >= 5), 1'b0);
      chk("coll_clr", 32'(clr), 32'(i == 5));
      chk("coll_inc", 32'(inc), 32'(i == 6));
    end
    chk("coll_count", 32'(dut_count), 32'd1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);

    // Reset in the middle of a debounce
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("midrst_inc", 32'(inc), 32'd0);
    for (int j = 0; j < 8; j++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("midrst_relatency", 32'(inc), 32'(j == 5));
    end
    chk("midrst_glitch", 32'(glitch_cnt), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);

    // Randomized segments against the model
    n = 0;
    cur_clr = 1'b0;
    while (n < 1500) begin
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) cur_clr = ~cur_clr;
        step(v, cur_clr, 1'($urandom_range(0, 199) == 0));
        n++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
